bitfusion_operand_packer: RTL and testbench
===========================================

Name: bitfusion_operand_packer

Overview:
- Streaming front end for the signed spatial fusion multiplier array.
- Accepts one low-precision operand element per cycle over a valid/ready stream and packs elements LSB-first into IN_WIDTH-bit operand words.
- Emits each packed word over a valid/ready stream with the matching per-level MODE_WIDTH mode vector.
- One instance per operand, A or B. The multiplier applies the B transpose internally, so both instances use the same layout.

Parameters:
- PRECISION, 8, top-level element precision in bits (maximum element width).
- L_PRECISION, 2, lowest element precision in bits.
- IN_WIDTH, (PRECISION/L_PRECISION)*PRECISION, packed word width.
- NUM_LEVELS, $clog2(PRECISION/L_PRECISION), number of fusion levels.
- MODE_WIDTH, 2*NUM_LEVELS, width of the mode vector.
- CNT_W, $clog2(IN_WIDTH/L_PRECISION+1), width of the element count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_prec  in  2  element width select: EW = L_PRECISION<<cfg_prec; values above NUM_LEVELS clamp to NUM_LEVELS.
- s_valid  in  1  input element valid.
- s_ready  out  1  packer can accept an element.
- s_data  in  PRECISION  element value; only bits [EW-1:0] are used.
- s_last  in  1  last element of a vector; closes the current word.
- m_valid  out  1  packed word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  IN_WIDTH  packed word.
- m_count  out  CNT_W  number of valid elements in m_data, from 1 to N.
- m_last  out  1  word was closed by s_last.
- m_mode  out  MODE_WIDTH  mode vector for the multiplier.

Behaviour:
- Word geometry:
  - EW = L_PRECISION<<sel, where sel is the latched cfg_prec.
  - N = IN_WIDTH/EW elements per word (defaults: 16, 8 or 4).
  - Element i occupies m_data[i*EW +: EW].
  - Unfilled positions are zero.
- cfg_prec latching: sampled on the handshake that accepts element 0 of a word. Changes mid-word are ignored until the next word.
- m_mode: level l (l=0 is top, field bits [MODE_WIDTH-1-2l -: 2]) is 2'b11 if l < NUM_LEVELS-sel, else 2'b00.
  - sel=0 -> 4'b1111.
  - sel=1 -> 4'b1100.
  - sel=2 -> 4'b0000.
- Storage: two stages.
  - Build register (acc, cnt, sel, last).
  - Output register (m_data, m_count, m_last, m_mode, m_valid).
  - Flag full marks that acc holds a closed word not yet transferred.
- Input handshake:
  - s_ready = !full.
  - An element is accepted when s_valid && s_ready. It writes into position cnt and increments cnt.
- Word close: a word closes on the acceptance of element N-1, or of any element with s_last=1.
  - If the output register is free, or is being drained this cycle (m_valid && m_ready), the closed word loads the output register at this edge. m_valid=1 the next cycle, giving 1-cycle latency. The build stage clears (cnt=0, acc=0).
  - Otherwise full=1. The word transfers on the first edge where the output register is free or drains, and full clears at that edge.
- Output handshake:
  - A transfer occurs on m_valid && m_ready.
  - m_valid clears unless a new word loads on the same edge.
  - All m_* outputs hold stable while m_valid && !m_ready.
- Throughput: one element per cycle sustained with m_ready=1, with no bubbles across word boundaries.
- Closed word with a single element: s_last accepted with cnt=0 yields m_count=1, m_last=1, and all other positions zero.
- No element is produced or dropped without a handshake. s_valid=1 with full=1 stalls.
- Reset (asynchronous, active-low):
  - m_valid=0, m_data=0, m_count=0, m_last=0, m_mode=0.
  - cnt=0, acc=0, full=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - A reset mid-word or with a word pending discards all state.
- Arithmetic: elements are unsigned bit fields. The packer does no sign extension; sign handling belongs to the multiplier.

Test Plan:
1. cfg_prec=0, 16 elements 0..3 repeating, m_ready=1 -> one word m_data=32'hE4E4E4E4, m_count=16, m_last=0, m_mode=4'b1111, m_valid the cycle after the 16th accept.
2. cfg_prec=2, elements 8'h11,8'h22,8'h33 with s_last on 8'h33 -> m_data=32'h00332211, m_count=3, m_last=1, m_mode=4'b0000.
3. Backpressure: cfg_prec=1, m_ready=0, 16 elements offered back-to-back.
   - Expected: the first word is held stable in the output register; s_ready drops after the 16th accept (full=1); no element is lost.
   - Then m_ready=1: the words stream out in order, both with m_mode=4'b1100 and m_count=8.
4. cfg_prec toggled 0->2 after element 3 of a word -> the current word still completes at 16 elements with m_mode=4'b1111; the next word uses EW=8.
5. Assert reset after 5 of 16 elements, plus one pending word -> m_valid=0 immediately; after release, a fresh 16-element word emits with no residue from the discarded elements.
6. cfg_prec=3 -> behaves as cfg_prec=2 (4 elements per word, m_mode=4'b0000).

Source files
------------

// File: rtl/bitfusion_operand_packer.sv
// Packs low-precision operand elements LSB-first into fusion-array words.
// Two-stage buffer: build register feeding a registered valid/ready output.
module bitfusion_operand_packer #(
  parameter int PRECISION   = 8,
  parameter int L_PRECISION = 2,
  parameter int IN_WIDTH    = (PRECISION/L_PRECISION)*PRECISION,
  parameter int NUM_LEVELS  = $clog2(PRECISION/L_PRECISION),
  parameter int MODE_WIDTH  = 2*NUM_LEVELS,
  parameter int CNT_W       = $clog2(IN_WIDTH/L_PRECISION+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            cfg_prec,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PRECISION-1:0]  s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_WIDTH-1:0]   m_data,
  output logic [CNT_W-1:0]      m_count,
  output logic                  m_last,
  output logic [MODE_WIDTH-1:0] m_mode
);

  localparam int MAXN = IN_WIDTH/L_PRECISION;
  localparam logic [1:0] SEL_MAX = 2'(NUM_LEVELS);

  function automatic logic [MODE_WIDTH-1:0] mode_of(
    input logic [1:0] sel
  );
    logic [MODE_WIDTH-1:0] m;
    m = '0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      if (l < NUM_LEVELS - int'(sel))
        m[MODE_WIDTH-1-2*l -: 2] = 2'b11;
    end
    return m;
  endfunction

  logic [IN_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            sel_q, sel_d;
  logic                  last_q, last_d;
  logic                  full_q, full_d;
  logic                  m_valid_q, m_valid_d;
  logic [IN_WIDTH-1:0]   m_data_q, m_data_d;
  logic [CNT_W-1:0]      m_count_q, m_count_d;
  logic                  m_last_q, m_last_d;
  logic [MODE_WIDTH-1:0] m_mode_q, m_mode_d;

  logic [1:0]           cfg_sel;
  logic [1:0]           cur_sel;
  int                   ew;
  int                   n_elem;
  logic [PRECISION-1:0] mask;
  logic [IN_WIDTH-1:0]  elem;
  logic [IN_WIDTH-1:0]  acc_nx;
  logic [CNT_W-1:0]     cnt_nx;
  logic                 accept;
  logic                 close;
  logic                 out_free;

  always_comb begin
    cfg_sel  = (cfg_prec > SEL_MAX) ? SEL_MAX : cfg_prec;
    // Precision is frozen once element 0 of a word is in.
    cur_sel  = (cnt_q == '0) ? cfg_sel : sel_q;
    ew       = L_PRECISION << cur_sel;
    n_elem   = MAXN >> cur_sel;
    mask     = PRECISION'((64'd1 << ew) - 64'd1);
    elem     = IN_WIDTH'(s_data & mask);
    acc_nx   = acc_q | (elem << (int'(cnt_q) * ew));
    cnt_nx   = cnt_q + CNT_W'(1);
    accept   = s_valid && !full_q;
    close    = accept && (s_last || (int'(cnt_nx) == n_elem));
    out_free = !m_valid_q || m_ready;
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    full_d    = full_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;
    m_last_d  = m_last_q;
    m_mode_d  = m_mode_q;
    if (m_valid_q && m_ready)
      m_valid_d = 1'b0;
    if (full_q) begin
      if (out_free) begin
        m_valid_d = 1'b1;
        m_data_d  = acc_q;
        m_count_d = cnt_q;
        m_last_d  = last_q;
        m_mode_d  = mode_of(sel_q);
        acc_d     = '0;
        cnt_d     = '0;
        last_d    = 1'b0;
        full_d    = 1'b0;
      end
    end else if (accept) begin
      if (close && out_free) begin
        m_valid_d = 1'b1;
        m_data_d  = acc_nx;
        m_count_d = cnt_nx;
        m_last_d  = s_last;
        m_mode_d  = mode_of(cur_sel);
        acc_d     = '0;
        cnt_d     = '0;
        last_d    = 1'b0;
      end else begin
        acc_d  = acc_nx;
        cnt_d  = cnt_nx;
        sel_d  = cur_sel;
        last_d = s_last;
        full_d = close;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= 1'b0;
      full_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
      m_last_q  <= 1'b0;
      m_mode_q  <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      full_q    <= full_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_count_q <= m_count_d;
      m_last_q  <= m_last_d;
      m_mode_q  <= m_mode_d;
    end
  end

  assign s_ready = !full_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_last  = m_last_q;
  assign m_mode  = m_mode_q;

endmodule

// File: tb/tb_bitfusion_operand_packer.sv
// Directed bench for bitfusion_operand_packer at default parameters.
// Inputs change 1ns after rising edges; outputs are observed at falling edges.
module tb_bitfusion_operand_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_prec;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_count;
  logic        m_last;
  logic [3:0]  m_mode;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  c;
    logic        l;
    logic [3:0]  m;
  } wd_t;

  wd_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  stalls = 0;

  bitfusion_operand_packer dut (
    .clk(clk), .reset(reset), .cfg_prec(cfg_prec),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_count(m_count),
    .m_last(m_last), .m_mode(m_mode)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && m_valid && m_ready)
      q.push_back({m_data, m_count, m_last, m_mode});

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && k < 200) begin
      tick(1);
      k++;
      stalls++;
    end
    if (!s_ready)
      chk("send.timeout", 64'(s_ready), 64'd1);
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_word(input string tag,
                             input logic [31:0] d,
                             input logic [4:0]  c,
                             input logic        l,
                             input logic [3:0]  m);
    wd_t w;
    chk({tag, ".avail"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      w = q.pop_front();
      chk({tag, ".data"}, 64'(w.d), 64'(d));
      chk({tag, ".count"}, 64'(w.c), 64'(c));
      chk({tag, ".last"}, 64'(w.l), 64'(l));
      chk({tag, ".mode"}, 64'(w.m), 64'(m));
    end
  endtask

  initial begin
    reset    = 1'b0;
    cfg_prec = 2'd0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    tick(2);
    chk("rst.m_valid", 64'(m_valid), 64'd0);
    chk("rst.m_data", 64'(m_data), 64'd0);
    chk("rst.m_count", 64'(m_count), 64'd0);
    chk("rst.m_last", 64'(m_last), 64'd0);
    chk("rst.m_mode", 64'(m_mode), 64'd0);
    reset = 1'b1;
    tick(1);
    chk("rst.s_ready", 64'(s_ready), 64'd1);

    // T1: 2-bit elements, full word, latency
    m_ready = 1'b1;
    cfg_prec = 2'd0;
    for (int i = 0; i < 15; i++) send(8'(i % 4), 1'b0);
    chk("t1.pre_valid", 64'(m_valid), 64'd0);
    send(8'd3, 1'b0);
    chk("t1.latency", 64'(m_valid), 64'd1);
    tick(3);
    expect_word("t1", 32'hE4E4E4E4, 5'd16, 1'b0, 4'b1111);
    chk("t1.extra", 64'(q.size()), 64'd0);

    // T2: 8-bit elements closed early by s_last
    cfg_prec = 2'd2;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    tick(3);
    expect_word("t2", 32'h00332211, 5'd3, 1'b1, 4'b0000);
    chk("t2.extra", 64'(q.size()), 64'd0);

    // T4: mid-word cfg change, upper bits must be masked
    stalls = 0;
    cfg_prec = 2'd0;
    for (int i = 0; i < 4; i++) send(8'hA8 | 8'(i % 4), 1'b0);
    cfg_prec = 2'd2;
    for (int i = 4; i < 16; i++) send(8'hA8 | 8'(i % 4), 1'b0);
    send(8'h44, 1'b0);
    send(8'h33, 1'b0);
    send(8'h22, 1'b0);
    send(8'h11, 1'b0);
    chk("t4.no_stall", 64'(stalls), 64'd0);
    tick(3);
    expect_word("t4a", 32'hE4E4E4E4, 5'd16, 1'b0, 4'b1111);
    expect_word("t4b", 32'h11223344, 5'd4, 1'b0, 4'b0000);
    chk("t4.extra", 64'(q.size()), 64'd0);

    // T3: backpressure, 4-bit elements
    m_ready = 1'b0;
    cfg_prec = 2'd1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("t3.s_ready", 64'(s_ready), 64'd0);
    chk("t3.m_valid", 64'(m_valid), 64'd1);
    tick(3);
    chk("t3.hold_data", 64'(m_data), 64'h76543210);
    chk("t3.hold_count", 64'(m_count), 64'd8);
    chk("t3.hold_valid", 64'(m_valid), 64'd1);
    chk("t3.still_full", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    tick(4);
    chk("t3.ready_back", 64'(s_ready), 64'd1);
    expect_word("t3a", 32'h76543210, 5'd8, 1'b0, 4'b1100);
    expect_word("t3b", 32'hFEDCBA98, 5'd8, 1'b0, 4'b1100);
    chk("t3.extra", 64'(q.size()), 64'd0);

    // T6: cfg_prec=3 clamps to 8-bit elements
    cfg_prec = 2'd3;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    tick(3);
    expect_word("t6", 32'hDDCCBBAA, 5'd4, 1'b0, 4'b0000);
    chk("t6.extra", 64'(q.size()), 64'd0);

    // T5: reset with a pending word and a partial word
    m_ready = 1'b0;
    cfg_prec = 2'd0;
    send(8'h03, 1'b1);
    chk("t5.single_data", 64'(m_data), 64'h3);
    chk("t5.single_count", 64'(m_count), 64'd1);
    chk("t5.single_last", 64'(m_last), 64'd1);
    for (int i = 0; i < 5; i++) send(8'h03, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5.rst_valid", 64'(m_valid), 64'd0);
    chk("t5.rst_data", 64'(m_data), 64'd0);
    chk("t5.rst_ready", 64'(s_ready), 64'd1);
    tick(2);
    reset = 1'b1;
    q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h01, 1'b0);
    tick(3);
    expect_word("t5", 32'h55555555, 5'd16, 1'b0, 4'b1111);
    chk("t5.extra", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
